// File: rtl/fminmax_stream.sv
// Streaming float min/max reduction with count and NaN-seen flag.
// Ports: clk, rst_n, mode, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_data/out_count/out_nan.
module fminmax_stream #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int MAX_LEN = 256,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] SIGN_BIT =
    {1'b1, {(W-1){1'b0}}};

  state_t           state;
  logic [W-1:0]     acc;
  logic             acc_nan;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;
  logic             nan_seen;

  logic             accept;
  logic             first;
  logic             in_nan;
  logic             mode_eff;
  logic [W-1:0]     k_in;
  logic [W-1:0]     k_acc;
  logic             better;
  logic             take;
  logic [W-1:0]     acc_nxt;
  logic             acc_nan_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             nan_nxt;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  // Monotone unsigned key: -0 sorts below +0.
  function automatic logic [W-1:0] key(input logic [W-1:0] x);
    return x[W-1] ? ~x : (x ^ SIGN_BIT);
  endfunction

  always_comb begin
    accept   = in_valid && in_ready;
    first    = (state == IDLE);
    in_nan   = is_nan(in_data);
    mode_eff = first ? mode : mode_q;
    k_in     = key(in_data);
    k_acc    = key(acc);
    better   = mode_eff ? (k_in > k_acc)
                        : (k_in < k_acc);
    // NaN never displaces a number; a number always displaces NaN.
    take        = first || (!in_nan && (acc_nan || better));
    acc_nxt     = take ? in_data : acc;
    acc_nan_nxt = take ? in_nan : acc_nan;
    if (first)
      cnt_nxt = CNT_W'(1);
    else if (cnt == CNT_MAX)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CNT_W'(1);
    nan_nxt = in_nan || (!first && nan_seen);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      acc_nan   <= 1'b0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      nan_seen  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_nan   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc      <= acc_nxt;
            acc_nan  <= acc_nan_nxt;
            mode_q   <= mode_eff;
            cnt      <= cnt_nxt;
            nan_seen <= nan_nxt;
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= acc_nan_nxt ? QNAN : acc_nxt;
              out_count <= cnt_nxt;
              out_nan   <= nan_nxt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fminmax_stream.sv
// Scoreboard bench for fminmax_stream: single and half precision.
// Directed packets push expected results; monitors pop on handshake.
module tb_fminmax_stream;

  typedef struct {
    logic [31:0] data;
    logic [8:0]  count;
    logic        nan;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mode_a, in_valid_a, in_ready_a, in_last_a;
  logic        out_valid_a, out_ready_a, out_nan_a;
  logic [31:0] in_data_a, out_data_a;
  logic [8:0]  out_count_a;

  logic        mode_b, in_valid_b, in_ready_b, in_last_b;
  logic        out_valid_b, out_ready_b, out_nan_b;
  logic [15:0] in_data_b, out_data_b;
  logic [2:0]  out_count_b;

  fminmax_stream dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_last(in_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_count(out_count_a),
    .out_nan(out_nan_a)
  );

  fminmax_stream #(.EXP_W(5), .MAN_W(10), .MAX_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_last(in_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_count(out_count_b),
    .out_nan(out_nan_b)
  );

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_a(input logic [31:0] d, input int c, input logic n);
    exp_t e;
    e.data = d; e.count = 9'(c); e.nan = n;
    qa.push_back(e);
  endtask

  task automatic expect_b(input logic [15:0] d, input int c, input logic n);
    exp_t e;
    e.data = {16'h0, d}; e.count = 9'(c); e.nan = n;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_data", out_data_a, e.data);
        chk("a_count", out_count_a, e.count);
        chk("a_nan", out_nan_a, e.nan);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_data", out_data_b, e.data[15:0]);
        chk("b_count", out_count_b, e.count[2:0]);
        chk("b_nan", out_nan_b, e.nan);
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic l, input logic m);
    int n = 0;
    in_valid_a = 1'b1; in_data_a = d; in_last_a = l; mode_a = m;
    while (!in_ready_a && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready_a) chk("a_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_last_a = 1'b0;
    if (l) chk("a_latency", out_valid_a, 1);
  endtask

  task automatic send_b(input logic [15:0] d, input logic l, input logic m);
    int n = 0;
    in_valid_b = 1'b1; in_data_b = d; in_last_b = l; mode_b = m;
    while (!in_ready_b && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready_b) chk("b_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid_b = 1'b0; in_last_b = 1'b0;
    if (l) chk("b_latency", out_valid_b, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mode_a = 0; in_valid_a = 0; in_last_a = 0; in_data_a = '0;
    out_ready_a = 1;
    mode_b = 0; in_valid_b = 0; in_last_b = 0; in_data_b = '0;
    out_ready_b = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_count", out_count_a, 0);
    chk("rst_out_nan", out_nan_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // min 1.0, -2.0, 0.5
    expect_a(32'hC000_0000, 3, 0);
    send_a(32'h3F80_0000, 0, 0);
    send_a(32'hC000_0000, 0, 0);
    send_a(32'h3F00_0000, 1, 0);
    @(posedge clk); #1;

    // max of same; mode flips after first beat must be ignored
    expect_a(32'h3F80_0000, 3, 0);
    send_a(32'h3F80_0000, 0, 1);
    send_a(32'hC000_0000, 0, 0);
    send_a(32'h3F00_0000, 1, 0);
    @(posedge clk); #1;

    // signed zeros
    expect_a(32'h8000_0000, 2, 0);
    send_a(32'h0000_0000, 0, 0);
    send_a(32'h8000_0000, 1, 0);
    @(posedge clk); #1;
    expect_a(32'h0000_0000, 2, 0);
    send_a(32'h0000_0000, 0, 1);
    send_a(32'h8000_0000, 1, 1);
    @(posedge clk); #1;

    // NaN mixed with a number
    expect_a(32'h4040_0000, 3, 1);
    send_a(32'h7FC0_0001, 0, 0);
    send_a(32'h4040_0000, 0, 0);
    send_a(32'h7F80_0001, 1, 0);
    @(posedge clk); #1;

    // all NaN
    expect_a(32'h7FC0_0000, 2, 1);
    send_a(32'hFFC0_0000, 0, 1);
    send_a(32'h7F80_0001, 1, 1);
    @(posedge clk); #1;

    // single -inf
    expect_a(32'hFF80_0000, 1, 0);
    send_a(32'hFF80_0000, 1, 0);
    @(posedge clk); #1;

    // backpressure then back-to-back packet
    out_ready_a = 1'b0;
    expect_a(32'h4000_0000, 2, 0);
    send_a(32'h4000_0000, 0, 1);
    send_a(32'hC080_0000, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_out_data", out_data_a, 32'h4000_0000);
      chk("bp_out_count", out_count_a, 2);
    end
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    expect_a(32'h4040_0000, 2, 0);
    send_a(32'h40A0_0000, 0, 0);
    send_a(32'h4040_0000, 1, 0);
    @(posedge clk); #1;

    // reset mid-packet
    send_a(32'hC000_0000, 0, 0);
    send_a(32'hC100_0000, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 1);
    chk("mid_rst_out_count", out_count_a, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_a(32'h3F80_0000, 1, 0);
    send_a(32'h3F80_0000, 1, 0);
    @(posedge clk); #1;

    // half precision min
    expect_b(16'hBC00, 2, 0);
    send_b(16'h3C00, 0, 0);
    send_b(16'hBC00, 1, 0);
    @(posedge clk); #1;

    // saturating count, max mode
    expect_b(16'h4400, 4, 0);
    send_b(16'h3C00, 0, 1);
    send_b(16'h4000, 0, 1);
    send_b(16'h4200, 0, 1);
    send_b(16'h3800, 0, 1);
    send_b(16'h4400, 0, 1);
    send_b(16'hC000, 1, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("qa_drained", 64'(qa.size()), 0);
    chk("qb_drained", 64'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
